// File: rtl/plic_tmr_sched_if.sv
// Configuration and cause-read port bundle between the interrupt target and the
// multi-channel timer scheduler.
interface plic_tmr_sched_if #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned CW   = 32
);
   localparam int unsigned CHW = $clog2(N_CH);
   localparam int unsigned IDW = $clog2(N_CH + 1);

   logic           cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic           cfg_sel;
   logic [CW-1:0]  cfg_wdata;
   logic           cause_re;
   logic [IDW-1:0] cause_id;

   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_wdata, cause_re,
      input  cause_id
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_wdata, cause_re,
      output cause_id
   );
endinterface

// File: rtl/plic_tmr_sched.sv
// N_CH periodic/one-shot timers sharing one PLIC source line; expiries latch into
// a pending vector, read and acknowledged round-robin through the cause port.
module plic_tmr_sched #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned CW   = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   plic_tmr_sched_if.slave bus,
   input  logic            irq_edge_i,
   output logic [N_CH-1:0] pending_o,
   output logic [N_CH-1:0] ovf_o,
   output logic            irq_o
);
   localparam int unsigned CHW = $clog2(N_CH);
   localparam int unsigned IDW = $clog2(N_CH + 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q  [N_CH];
   state_e          state_d  [N_CH];
   logic [CW-1:0]   period_q [N_CH];
   logic [CW-1:0]   period_d [N_CH];
   logic [CW-1:0]   cnt_q    [N_CH];
   logic [CW-1:0]   cnt_d    [N_CH];
   logic [N_CH-1:0] periodic_q, periodic_d;
   logic [N_CH-1:0] pending_q, pending_d;
   logic [N_CH-1:0] ovf_q, ovf_d;
   logic [N_CH-1:0] expire;
   logic [CHW-1:0]  rr_q, rr_d;
   logic [CHW-1:0]  arb_idx, win_idx;
   logic            win_vld, ack;
   logic            rise_q, rise_d;
   logic            irq_q, irq_d;

   // Round-robin search from rr+1; descending loop lets the nearest candidate win.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      arb_idx = '0;
      for (int unsigned i = N_CH; i >= 1; i--) begin
         arb_idx = CHW'((32'(rr_q) + i) % N_CH);
         if (pending_q[arb_idx]) begin
            win_vld = 1'b1;
            win_idx = arb_idx;
         end
      end
   end

   assign bus.cause_id = win_vld ? (IDW'(win_idx) + IDW'(1)) : '0;
   assign ack          = bus.cause_re & win_vld;

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      cnt_d      = cnt_q;
      periodic_d = periodic_q;
      pending_d  = pending_q;
      ovf_d      = ovf_q;
      expire     = '0;
      rr_d       = rr_q;
      rise_d     = 1'b0;

      for (int unsigned ch = 0; ch < N_CH; ch++) begin
         case (state_q[ch])
            RUN: begin
               if (cnt_q[ch] == '0) begin
                  expire[ch] = 1'b1;
                  if (periodic_q[ch]) cnt_d[ch] = period_q[ch];
                  else                state_d[ch] = IDLE;
               end else begin
                  cnt_d[ch] = cnt_q[ch] - CW'(1);
               end
            end
            default: ;
         endcase

         // A config write overrides the counter/state update of a same-cycle expiry.
         if (bus.cfg_we && (bus.cfg_ch == CHW'(ch))) begin
            if (!bus.cfg_sel) begin
               period_d[ch] = bus.cfg_wdata;
            end else begin
               periodic_d[ch] = bus.cfg_wdata[1];
               if (bus.cfg_wdata[0] && bus.cfg_wdata[2]) begin
                  state_d[ch] = RUN;
                  cnt_d[ch]   = period_q[ch];
               end else begin
                  state_d[ch] = IDLE;
                  cnt_d[ch]   = '0;
               end
            end
         end

         // Ack clears ovf unconditionally; a coincident expiry re-sets pending.
         if (expire[ch] && pending_q[ch]) ovf_d[ch] = 1'b1;
         if (ack && (win_idx == CHW'(ch))) begin
            pending_d[ch] = 1'b0;
            ovf_d[ch]     = 1'b0;
            if (expire[ch]) rise_d = 1'b1;
         end
         if (expire[ch]) begin
            pending_d[ch] = 1'b1;
            if (!pending_q[ch]) rise_d = 1'b1;
         end
      end

      if (ack) rr_d = win_idx;
      irq_d = irq_edge_i ? rise_q : (|pending_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_q[ch]  <= IDLE;
            period_q[ch] <= '0;
            cnt_q[ch]    <= '0;
         end
         periodic_q <= '0;
         pending_q  <= '0;
         ovf_q      <= '0;
         rr_q       <= '0;
         rise_q     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         periodic_q <= periodic_d;
         pending_q  <= pending_d;
         ovf_q      <= ovf_d;
         rr_q       <= rr_d;
         rise_q     <= rise_d;
         irq_q      <= irq_d;
      end
   end

   assign pending_o = pending_q;
   assign ovf_o     = ovf_q;
   assign irq_o     = irq_q;
endmodule

// File: tb/tb_plic_tmr_sched.sv
// Directed bench for plic_tmr_sched: cycle-tagged expectations go into a queue as
// stimulus is issued; a negedge monitor compares them against the DUT outputs.
module tb_plic_tmr_sched;
   localparam int K_PEND  = 0;
   localparam int K_OVF   = 1;
   localparam int K_IRQ   = 2;
   localparam int K_CAUSE = 3;

   typedef struct {
      int    cyc;
      int    kind;
      int    val;
      string name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       irq_edge = 1'b0;
   logic [3:0] pending;
   logic [3:0] ovf;
   logic       irq;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   exp_t       exp_q[$];

   plic_tmr_sched_if #(.N_CH(4), .CW(32)) bus_if ();

   plic_tmr_sched #(.N_CH(4), .CW(32)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .bus        (bus_if),
      .irq_edge_i (irq_edge),
      .pending_o  (pending),
      .ovf_o      (ovf),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int t, input int kind, input int val, input string nm);
      exp_t e;
      e.cyc  = t;
      e.kind = kind;
      e.val  = val;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_wr(input int ch, input int sel, input int data);
      int t;
      t = cyc + 1;
      bus_if.cfg_we    = 1'b1;
      bus_if.cfg_ch    = 2'(ch);
      bus_if.cfg_sel   = 1'(sel);
      bus_if.cfg_wdata = 32'(data);
      goto(t);
      bus_if.cfg_we    = 1'b0;
   endtask

   task automatic ack_rd();
      int t;
      t = cyc + 1;
      bus_if.cause_re = 1'b1;
      goto(t);
      bus_if.cause_re = 1'b0;
   endtask

   // Monitor: every cycle, compare all expectations tagged with this cycle.
   always @(negedge clk) begin
      int act;
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
         if (exp_q[k].cyc <= cyc) begin
            case (exp_q[k].kind)
               K_PEND:  act = int'(pending);
               K_OVF:   act = int'(ovf);
               K_IRQ:   act = int'(irq);
               default: act = int'(bus_if.cause_id);
            endcase
            checks++;
            if (exp_q[k].cyc < cyc) begin
               failures++;
               $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                        exp_q[k].name, exp_q[k].cyc, cyc);
            end else if (act != exp_q[k].val) begin
               failures++;
               $display("FAIL %s @cyc %0d: got %0d expected %0d",
                        exp_q[k].name, cyc, act, exp_q[k].val);
            end
            exp_q.delete(k);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int t;
      bus_if.cfg_we    = 1'b0;
      bus_if.cfg_ch    = '0;
      bus_if.cfg_sel   = 1'b0;
      bus_if.cfg_wdata = '0;
      bus_if.cause_re  = 1'b0;

      // Reset state
      expect_at(1, K_PEND, 0, "rst_pend");
      expect_at(1, K_OVF, 0, "rst_ovf");
      expect_at(1, K_IRQ, 0, "rst_irq");
      expect_at(1, K_CAUSE, 0, "rst_cause");
      goto(2);
      rst_ni = 1'b1;
      goto(4);

      // Ch0 period 3 periodic, level mode, ack then stop
      b = cyc;
      t = b + 1;
      expect_at(t + 4, K_PEND, 0, "t1_pend_pre");
      expect_at(t + 5, K_PEND, 1, "t1_pend_rise");
      expect_at(t + 5, K_IRQ, 0, "t1_irq_lat");
      expect_at(t + 5, K_CAUSE, 1, "t1_cause");
      expect_at(t + 6, K_IRQ, 1, "t1_irq_hi");
      expect_at(t + 7, K_PEND, 0, "t1_pend_ack");
      expect_at(t + 7, K_IRQ, 1, "t1_irq_hold");
      expect_at(t + 8, K_IRQ, 0, "t1_irq_fall");
      expect_at(t + 8, K_PEND, 0, "t1_pend_gap");
      expect_at(t + 9, K_PEND, 1, "t1_pend_rise2");
      expect_at(t + 10, K_IRQ, 1, "t1_irq_hi2");
      expect_at(t + 11, K_CAUSE, 1, "t1_cause2");
      expect_at(t + 12, K_PEND, 0, "t1_pend_ack2");
      expect_at(t + 12, K_OVF, 0, "t1_ovf");
      expect_at(t + 13, K_IRQ, 0, "t1_irq_fall2");
      expect_at(t + 16, K_PEND, 0, "t1_stopped");
      cfg_wr(0, 0, 3);
      cfg_wr(0, 1, 7);
      goto(t + 6);
      ack_rd();
      goto(t + 10);
      cfg_wr(0, 1, 0);
      ack_rd();
      goto(t + 17);

      // Ch2 one-shot period 0
      b = cyc;
      t = b + 1;
      expect_at(t + 1, K_PEND, 0, "t2_pend_pre");
      expect_at(t + 2, K_PEND, 4, "t2_pend_set");
      expect_at(t + 2, K_CAUSE, 3, "t2_cause");
      expect_at(t + 3, K_PEND, 4, "t2_pend_once");
      expect_at(t + 3, K_IRQ, 1, "t2_irq");
      expect_at(t + 4, K_PEND, 0, "t2_pend_ack");
      expect_at(t + 4, K_CAUSE, 0, "t2_cause_none");
      expect_at(t + 5, K_IRQ, 0, "t2_irq_fall");
      expect_at(t + 8, K_PEND, 0, "t2_no_more");
      cfg_wr(2, 0, 0);
      cfg_wr(2, 1, 5);
      goto(t + 3);
      ack_rd();
      goto(t + 9);

      // Round-robin: bring rr to 0, then ch0, ch1, ch3 pending
      b = cyc;
      t = b + 1;
      expect_at(t + 2, K_CAUSE, 1, "t3_cause_ch0");
      expect_at(t + 3, K_PEND, 0, "t3_pend_clr");
      expect_at(t + 4, K_IRQ, 0, "t3_irq_low");
      expect_at(t + 6, K_IRQ, 1, "t3_irq_hi");
      expect_at(t + 7, K_PEND, 11, "t3_pend_three");
      expect_at(t + 8, K_CAUSE, 2, "t3_rr_first");
      expect_at(t + 9, K_CAUSE, 4, "t3_rr_second");
      expect_at(t + 9, K_PEND, 9, "t3_pend_a");
      expect_at(t + 10, K_CAUSE, 1, "t3_rr_third");
      expect_at(t + 10, K_PEND, 1, "t3_pend_b");
      expect_at(t + 11, K_CAUSE, 0, "t3_rr_empty");
      expect_at(t + 11, K_PEND, 0, "t3_pend_c");
      expect_at(t + 11, K_IRQ, 1, "t3_irq_last");
      expect_at(t + 12, K_IRQ, 0, "t3_irq_fall");
      expect_at(t + 12, K_CAUSE, 0, "t3_noop_ack");
      cfg_wr(0, 0, 0);
      cfg_wr(0, 1, 5);
      goto(t + 2);
      ack_rd();
      cfg_wr(0, 1, 5);
      cfg_wr(1, 1, 5);
      cfg_wr(3, 1, 5);
      goto(t + 8);
      ack_rd();
      ack_rd();
      ack_rd();
      ack_rd();
      goto(t + 13);

      // Ch1 period 2 periodic, overrun on second expiry
      b = cyc;
      t = b + 1;
      expect_at(t + 3, K_PEND, 0, "t4_pend_pre");
      expect_at(t + 4, K_PEND, 2, "t4_pend_set");
      expect_at(t + 6, K_OVF, 0, "t4_ovf_pre");
      expect_at(t + 7, K_OVF, 2, "t4_ovf_set");
      expect_at(t + 7, K_PEND, 2, "t4_pend_hold");
      expect_at(t + 8, K_CAUSE, 2, "t4_cause");
      expect_at(t + 9, K_PEND, 0, "t4_pend_ack");
      expect_at(t + 9, K_OVF, 0, "t4_ovf_ack");
      expect_at(t + 10, K_PEND, 0, "t4_stopped");
      cfg_wr(1, 0, 2);
      cfg_wr(1, 1, 7);
      goto(t + 7);
      cfg_wr(1, 1, 0);
      ack_rd();
      goto(t + 11);

      // Edge mode: simultaneous expiry, then ack coinciding with re-expiry
      b = cyc;
      t = b + 2;
      irq_edge = 1'b1;
      expect_at(t + 3, K_PEND, 3, "t5_pend_both");
      expect_at(t + 3, K_IRQ, 0, "t5_irq_lat");
      expect_at(t + 3, K_CAUSE, 1, "t5_cause");
      expect_at(t + 4, K_IRQ, 1, "t5_pulse");
      expect_at(t + 5, K_IRQ, 0, "t5_pulse_end");
      expect_at(t + 5, K_CAUSE, 2, "t5_cause2");
      expect_at(t + 6, K_PEND, 0, "t5_pend_clr");
      expect_at(t + 8, K_PEND, 4, "t5_p0_set");
      expect_at(t + 9, K_IRQ, 1, "t5_p0_pulse");
      expect_at(t + 9, K_OVF, 4, "t5_p0_ovf");
      expect_at(t + 10, K_IRQ, 0, "t5_p0_low");
      expect_at(t + 10, K_CAUSE, 3, "t5_p0_cause");
      expect_at(t + 11, K_PEND, 4, "t5_setwins_pend");
      expect_at(t + 11, K_OVF, 0, "t5_setwins_ovf");
      expect_at(t + 11, K_IRQ, 0, "t5_setwins_lat");
      expect_at(t + 12, K_IRQ, 1, "t5_setwins_pulse");
      expect_at(t + 12, K_OVF, 4, "t5_ovf_again");
      expect_at(t + 13, K_IRQ, 0, "t5_setwins_end");
      expect_at(t + 14, K_CAUSE, 3, "t5_stop_cause");
      expect_at(t + 15, K_PEND, 0, "t5_final_pend");
      expect_at(t + 15, K_OVF, 0, "t5_final_ovf");
      expect_at(t + 16, K_IRQ, 0, "t5_final_irq");
      expect_at(t + 17, K_PEND, 0, "t5_idle");
      cfg_wr(0, 0, 1);
      cfg_wr(1, 0, 0);
      cfg_wr(0, 1, 5);
      cfg_wr(1, 1, 5);
      goto(t + 4);
      ack_rd();
      ack_rd();
      cfg_wr(2, 1, 7);
      goto(t + 10);
      ack_rd();
      goto(t + 13);
      cfg_wr(2, 1, 0);
      ack_rd();
      goto(t + 18);
      irq_edge = 1'b0;
      goto(t + 20);

      // Asynchronous reset while ch3 runs with cnt=5 and ch1 is pending
      b = cyc;
      t = b + 1;
      expect_at(t + 3, K_PEND, 2, "t6_pend_pre");
      expect_at(t + 3, K_CAUSE, 2, "t6_cause_pre");
      expect_at(t + 4, K_PEND, 0, "t6_rst_pend");
      expect_at(t + 4, K_IRQ, 0, "t6_rst_irq");
      expect_at(t + 4, K_CAUSE, 0, "t6_rst_cause");
      expect_at(t + 4, K_OVF, 0, "t6_rst_ovf");
      expect_at(t + 7, K_IRQ, 0, "t6_rel_irq");
      expect_at(t + 12, K_PEND, 0, "t6_no_expiry");
      expect_at(t + 13, K_IRQ, 0, "t6_irq_quiet");
      cfg_wr(3, 0, 8);
      cfg_wr(3, 1, 7);
      cfg_wr(1, 1, 5);
      goto(t + 4);
      rst_ni = 1'b0;
      goto(t + 6);
      rst_ni = 1'b1;
      goto(t + 16);

      foreach (exp_q[k]) begin
         checks++;
         failures++;
         $display("FAIL %s: never compared (cycle %0d)", exp_q[k].name, exp_q[k].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/plic_tmr_sched.md
# plic_tmr_sched

Multi-channel periodic/one-shot interrupt scheduler that shares a single PLIC interrupt source line between N_CH independent timer channels. It sits beside the PLIC, replacing a single-timer source feed. It latches per-channel expiries into a pending vector and drives one glitch-free source line into the PLIC gateway, in level or edge form. The interrupt target reads a cause port to obtain the next expired channel, chosen round-robin; the read also acknowledges that channel.

## Interface
- N_CH, 4, number of timer channels (2..16)
- CW, 32, counter/period width
- CHW, $clog2(N_CH), channel index width
- IDW, $clog2(N_CH+1), cause id width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  configuration write strobe, single cycle
- cfg_ch_i  in  CHW  channel addressed by write
- cfg_sel_i  in  1  0: period register, 1: control register
- cfg_wdata_i  in  CW  write data; control uses bit0 enable, bit1 periodic, bit2 start
- irq_edge_i  in  1  0: level output, 1: edge (pulse) output
- cause_re_i  in  1  target cause read/acknowledge strobe
- cause_id_o  out  IDW  0 = nothing pending, else granted channel+1
- pending_o  out  N_CH  per-channel pending bits
- ovf_o  out  N_CH  per-channel overrun flags (expiry while already pending)
- irq_o  out  1  source line to the PLIC gateway

## Operation
- Reset: all periods, counters, control, pending, ovf, rr pointer = 0. All channels are IDLE. irq_o=0, cause_id_o=0.
- Per-channel FSM: IDLE, RUN.
  - IDLE -> RUN: control write with enable=1 and start=1. cnt <= period.
  - RUN -> IDLE: control write with start=0 or enable=0. cnt <= 0. Pending and ovf are untouched.
  - Control write with start=1 while in RUN restarts: cnt <= period.
- RUN count: if cnt==0, the channel expires.
  - Periodic mode: cnt <= period and stay in RUN.
  - One-shot mode: go to IDLE.
  - Otherwise cnt <= cnt-1.
  - Period P gives an expiry every P+1 cycles; P=0 expires every cycle.
- Period write takes effect at the next load (start or reload); it never alters a running cnt.
- Expiry: pending[ch] <= 1. If pending[ch] was already 1, ovf[ch] <= 1.
- Arbiter: round-robin over pending_q. The search starts at rr+1 (mod N_CH), where rr is the last acknowledged channel. cause_id_o = winner+1, or 0 if none. It is combinational from registered state.
- Acknowledge: when cause_re_i=1 and cause_id_o!=0:
  - pending[cause_id_o-1] <= 0 and ovf[cause_id_o-1] <= 0.
  - rr <= cause_id_o-1.
  - cause_re_i with cause_id_o==0 has no effect.
- Simultaneous expiry and acknowledge of the same channel: set wins. Pending stays 1, ovf is cleared, rr advances.
- Level mode: irq_o <= |pending_q.
- Edge mode: irq_o <= 1 for one cycle whenever any pending bit goes 0->1 (including set-wins-over-ack). Otherwise 0.
- A change on irq_edge_i takes effect on the next registered irq_o value.

## Timing
- Control write in cycle t: cnt loaded at edge t+1. The first decrement is evaluated in cycle t+1.
- Expiry evaluated in cycle t (cnt==0): pending_o and ovf_o update at t+1, cause_id_o is valid at t+1, irq_o responds at t+2.
- Acknowledge in cycle t: pending_o clears at t+1. Level irq_o falls at t+2 if no other bit is pending.
- Config write and expiry of the same channel in the same cycle: the write wins for cnt and state, and the expiry still sets pending.
- Asynchronous reset mid-operation: all state is cleared immediately. irq_o=0 with no pulse on release.

## Test plan
- Ch0 period=3, periodic, level mode. Write enable|periodic|start at t=0 -> pending_o[0] rises at t=5, 9, 13; irq_o high from t=6. An ack at t=6 drops pending at t=7; irq_o drops at t=8, then rises again after the next expiry.
- Ch2 period=0, one-shot -> exactly one expiry. Ch2 returns to IDLE and pending_o=4'b0100. No further pending after an ack.
- Ch0, ch1 and ch3 pending with rr=0 -> successive acks return cause_id_o = 2, 4, 1, then 0. irq_o (level) drops only after the last ack.
- Ch1 period=2 periodic, never acked -> the second expiry sets ovf_o[1]=1. An ack clears both pending_o[1] and ovf_o[1].
- Edge mode, ch0 and ch1 expire in the same cycle -> a single 1-cycle irq_o pulse. An ack coinciding with re-expiry of a periodic period=0 channel keeps pending=1 and produces a new pulse.
- Reset asserted while ch3 is RUNning with cnt=5 -> all outputs are 0 immediately. After release there is no expiry until a new start write.
